fifo_flow_tx: RTL and testbench



---
 rtl/fifo_flow_pkg.sv | 21 ++
 rtl/fifo_flow_tx.sv | 104 ++++++++++
 tb/tb_fifo_flow_tx.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_flow_pkg.sv
// Shared definitions for the FIFO-to-FIFO flow-control transmitter:
// state encoding and threshold legality check.
package fifo_flow_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  // Thresholds are legal when almost-empty sits strictly below almost-full and
  // almost-full leaves at least one free slot for the word still in flight.
  function automatic bit cfg_legal(input logic [3:0] umbral_a,
                                   input logic [3:0] umbral_b,
                                   input int mem_length);
    return (umbral_b < umbral_a) && (int'(umbral_a) <= mem_length - 1);
  endfunction

endpackage

// File: rtl/fifo_flow_tx.sv
// Drains an upstream FIFO into a downstream FIFO, honouring the downstream
// pause/continua hysteresis and owning the downstream threshold registers.
module fifo_flow_tx
  import fifo_flow_pkg::*;
#(
  parameter int BUS_SIZE     = 5,
  parameter int ADDR_WIDTH   = 3,
  parameter int UMBRAL_A_RST = 6,
  parameter int UMBRAL_B_RST = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [3:0]          umbralA_in,
  input  logic [3:0]          umbralB_in,
  input  logic                src_empty,
  input  logic [BUS_SIZE-1:0] src_data,
  input  logic                src_valid,
  output logic                src_pop,
  input  logic                dst_pause,
  input  logic                dst_continua,
  input  logic                dst_fifo_error,
  output logic                dst_push,
  output logic [BUS_SIZE-1:0] dst_data,
  output logic                dst_valid,
  output logic [3:0]          umbralA,
  output logic [3:0]          umbralB,
  output logic [2:0]          state,
  output logic                cfg_error,
  output logic [7:0]          sent_count
);

  localparam int MEM_LENGTH = 1 << ADDR_WIDTH;

  state_t st;
  logic   pop_d;

  // Handshake: a pop in cycle N makes the upstream word valid in cycle N+1,
  // where it is pushed downstream unconditionally (pop_d). Pause gates the pop
  // combinationally, so at most the single in-flight word lands after pause.
  assign src_pop   = (st == ST_ACTIVE) && !src_empty && !dst_pause;
  assign dst_push  = pop_d;
  assign dst_data  = pop_d ? src_data : '0;
  assign dst_valid = pop_d & src_valid;
  assign state     = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= ST_INIT;
      umbralA   <= 4'(UMBRAL_A_RST);
      umbralB   <= 4'(UMBRAL_B_RST);
      cfg_error <= 1'b0;
    end else begin
      case (st)
        ST_INIT: begin
          if (init) begin
            umbralA <= umbralA_in;
            umbralB <= umbralB_in;
          end else if (cfg_legal(umbralA, umbralB, MEM_LENGTH)) begin
            st <= ST_IDLE;
          end else begin
            st        <= ST_ERROR;
            cfg_error <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (dst_fifo_error)               st <= ST_ERROR;
          else if (init)                    st <= ST_INIT;
          else if (!src_empty && !dst_pause) st <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (dst_fifo_error) st <= ST_ERROR;
          else if (init)      st <= ST_INIT;
          else if (dst_pause) st <= ST_PAUSE;
          else if (src_empty) st <= ST_IDLE;
        end
        ST_PAUSE: begin
          if (dst_fifo_error)    st <= ST_ERROR;
          else if (init)         st <= ST_INIT;
          else if (dst_continua) st <= src_empty ? ST_IDLE : ST_ACTIVE;
        end
        ST_ERROR: begin
          // A concurrent overflow keeps us here; init is taken once it clears.
          if (!dst_fifo_error && init) begin
            st        <= ST_INIT;
            cfg_error <= 1'b0;
          end
        end
        default: st <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_d      <= 1'b0;
      sent_count <= 8'd0;
    end else begin
      pop_d <= src_pop;
      if (pop_d) sent_count <= sent_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_fifo_flow_tx.sv
// Self-checking bench for fifo_flow_tx: behavioural upstream FIFO, directly
// driven downstream flags, and a scoreboard on the downstream push stream.
module tb_fifo_flow_tx;

  localparam int W = 5;

  logic         clk;
  logic         reset;
  logic         init;
  logic [3:0]   umbralA_in;
  logic [3:0]   umbralB_in;
  logic         src_empty;
  logic [W-1:0] src_data;
  logic         src_valid;
  logic         src_pop;
  logic         dst_pause;
  logic         dst_continua;
  logic         dst_fifo_error;
  logic         dst_push;
  logic [W-1:0] dst_data;
  logic         dst_valid;
  logic [3:0]   umbralA;
  logic [3:0]   umbralB;
  logic [2:0]   state;
  logic         cfg_error;
  logic [7:0]   sent_count;

  localparam logic [2:0] S_INIT = 3'd0, S_IDLE = 3'd1, S_ACTIVE = 3'd2,
                         S_PAUSE = 3'd3, S_ERROR = 3'd4;

  int n_vec = 0;
  int n_err = 0;
  int push_cnt = 0;
  int loaded_cnt = 0;
  int popped_cnt = 0;
  logic [W-1:0] up_q[$];
  logic [W-1:0] exp_q[$];

  fifo_flow_tx #(.BUS_SIZE(W), .ADDR_WIDTH(3), .UMBRAL_A_RST(6), .UMBRAL_B_RST(2)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbralA_in(umbralA_in), .umbralB_in(umbralB_in),
    .src_empty(src_empty), .src_data(src_data), .src_valid(src_valid), .src_pop(src_pop),
    .dst_pause(dst_pause), .dst_continua(dst_continua), .dst_fifo_error(dst_fifo_error),
    .dst_push(dst_push), .dst_data(dst_data), .dst_valid(dst_valid),
    .umbralA(umbralA), .umbralB(umbralB), .state(state),
    .cfg_error(cfg_error), .sent_count(sent_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream FIFO model: word appears on data_out the cycle after the pop.
  assign src_empty = (loaded_cnt == popped_cnt);
  always @(posedge clk) begin
    if (src_pop) begin
      src_data   <= up_q.pop_front();
      src_valid  <= 1'b1;
      popped_cnt <= popped_cnt + 1;
    end else begin
      src_valid  <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard on the downstream side
  always @(negedge clk) begin
    if (dst_push) begin
      push_cnt <= push_cnt + 1;
      if (exp_q.size() == 0) check("unexpected_push", 1, 0);
      else check("push_data", 32'(dst_data), 32'(exp_q.pop_front()));
      check("push_valid", 32'(dst_valid), 1);
    end else begin
      check("idle_data", 32'(dst_data), 0);
      check("idle_valid", 32'(dst_valid), 0);
    end
  end

  // Driver tasks
  task automatic load(input logic [W-1:0] w);
    up_q.push_back(w);
    exp_q.push_back(w);
    loaded_cnt++;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; init = 1'b0;
    dst_pause = 1'b0; dst_continua = 1'b0; dst_fifo_error = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'(S_INIT));
    check("rst_push", 32'(dst_push), 0);
    check("rst_pop", 32'(src_pop), 0);
    check("rst_data", 32'(dst_data), 0);
    check("rst_valid", 32'(dst_valid), 0);
    check("rst_umbralA", 32'(umbralA), 6);
    check("rst_umbralB", 32'(umbralB), 2);
    check("rst_cfg_error", 32'(cfg_error), 0);
    check("rst_sent", 32'(sent_count), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_init(input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] exp_st, input logic exp_cfg);
    @(negedge clk);
    init = 1'b1; umbralA_in = a; umbralB_in = b;
    @(negedge clk);
    @(negedge clk);
    init = 1'b0;
    @(negedge clk); #1;
    check("init_state", 32'(state), 32'(exp_st));
    check("init_umbralA", 32'(umbralA), 32'(a));
    check("init_umbralB", 32'(umbralB), 32'(b));
    check("init_cfg_error", 32'(cfg_error), 32'(exp_cfg));
  endtask

  task automatic wait_drain(input int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && src_empty && !dst_push) done = 1'b1;
    end
    check("drain_done", 32'(done), 1);
  endtask

  initial begin
    int base;
    bit seen;
    reset = 1'b1; init = 1'b0; umbralA_in = 4'd0; umbralB_in = 4'd0;
    dst_pause = 1'b0; dst_continua = 1'b0; dst_fifo_error = 1'b0;

    // Reset, no init: reset thresholds are legal, IDLE on first cycle
    reset_dut();
    @(negedge clk); #1;
    check("no_init_idle", 32'(state), 32'(S_IDLE));

    // Threshold configuration, including boundary and illegal cases
    do_init(4'd6, 4'd2, S_IDLE, 1'b0);
    do_init(4'd7, 4'd0, S_IDLE, 1'b0);
    do_init(4'd8, 4'd2, S_ERROR, 1'b1);
    do_init(4'd4, 4'd4, S_ERROR, 1'b1);
    do_init(4'd3, 4'd5, S_ERROR, 1'b1);
    @(negedge clk);
    load(5'd9); load(5'd10);
    repeat (4) begin
      @(negedge clk); #1;
      check("cfgerr_no_pop", 32'(src_pop), 0);
      check("cfgerr_state", 32'(state), 32'(S_ERROR));
    end
    do_init(4'd6, 4'd2, S_IDLE, 1'b0);
    wait_drain(20);

    // Four-word stream: first push 2 cycles after src_empty falls
    reset_dut();
    @(negedge clk);
    for (int i = 1; i <= 4; i++) load(W'(i));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      check("stream_push", 32'(dst_push), 32'(k >= 2 && k <= 5));
      if (k == 1) check("stream_pop1", 32'(src_pop), 1);
    end
    wait_drain(10);
    check("stream_sent", 32'(sent_count), 4);
    check("stream_idle", 32'(state), 32'(S_IDLE));

    // Pause after the third pop: exactly one in-flight word lands
    reset_dut();
    @(negedge clk);
    base = push_cnt;
    for (int i = 0; i < 5; i++) load(W'($urandom_range(0, 31)));
    @(negedge clk); #1;
    check("p_pop1", 32'(src_pop), 1);
    @(negedge clk);
    @(negedge clk); #1;
    check("pre_pause_pushes", 32'(push_cnt - base), 2);
    @(negedge clk);
    dst_pause = 1'b1;
    #1;
    check("pause_pop_stops", 32'(src_pop), 0);
    check("pause_inflight", 32'(dst_push), 1);
    repeat (3) begin
      @(negedge clk); #1;
      check("pause_state", 32'(state), 32'(S_PAUSE));
      check("pause_no_push", 32'(dst_push), 0);
    end
    check("pause_pushes", 32'(push_cnt - base), 3);
    @(negedge clk);
    dst_pause = 1'b0; dst_continua = 1'b1;
    @(negedge clk);
    dst_continua = 1'b0;
    #1;
    check("resume_state", 32'(state), 32'(S_ACTIVE));
    check("resume_pop", 32'(src_pop), 1);
    wait_drain(10);
    check("pause_sent", 32'(sent_count), 5);

    // Counter wrap: 257 words
    reset_dut();
    @(negedge clk);
    for (int i = 0; i < 257; i++) load(W'($urandom_range(0, 31)));
    wait_drain(400);
    check("wrap_sent", 32'(sent_count), 1);

    // Overflow in ACTIVE; then init together with overflow
    reset_dut();
    @(negedge clk);
    for (int i = 1; i <= 4; i++) load(W'(20 + i));
    @(negedge clk);
    @(negedge clk);
    dst_fifo_error = 1'b1;
    @(negedge clk);
    dst_fifo_error = 1'b0;
    #1;
    check("ovf_state", 32'(state), 32'(S_ERROR));
    check("ovf_inflight", 32'(dst_push), 1);
    check("ovf_cfg_error", 32'(cfg_error), 0);
    repeat (4) begin
      @(negedge clk); #1;
      check("ovf_no_pop", 32'(src_pop), 0);
      check("ovf_no_push", 32'(dst_push), 0);
    end
    check("ovf_sent", 32'(sent_count), 2);
    @(negedge clk);
    init = 1'b1; dst_fifo_error = 1'b1; umbralA_in = 4'd6; umbralB_in = 4'd2;
    @(negedge clk);
    dst_fifo_error = 1'b0;
    #1;
    check("err_beats_init", 32'(state), 32'(S_ERROR));
    @(negedge clk); #1;
    check("init_after_err", 32'(state), 32'(S_INIT));
    init = 1'b0;
    @(negedge clk); #1;
    check("reinit_idle", 32'(state), 32'(S_IDLE));
    wait_drain(20);
    check("reinit_sent", 32'(sent_count), 4);

    // Asynchronous reset with a word in flight
    @(negedge clk);
    for (int i = 0; i < 3; i++) load(W'(i + 1));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      if (dst_push) seen = 1'b1;
    end
    check("inflight_seen", 32'(seen), 1);
    reset = 1'b1;
    #1;
    check("async_push", 32'(dst_push), 0);
    check("async_data", 32'(dst_data), 0);
    check("async_sent", 32'(sent_count), 0);
    check("async_state", 32'(state), 32'(S_INIT));
    exp_q.delete();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
